// File: rtl/mlab_dcfifo_pkg.sv
// rtl/mlab_dcfifo_pkg.sv - shared constants and helpers for the MLAB dual-clock FIFO read side
package mlab_dcfifo_pkg;

    localparam int WORD_W      = 20;
    localparam int FIFO_USED_W = 6;
    localparam int RD_LAT_DEF  = 2;

    // Width of an occupancy count that must also represent the full value n.
    function automatic int clog2_p1(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mlab_stream_buf.sv
// rtl/mlab_stream_buf.sv - W x DEPTH register circular buffer, show-ahead head, push/pop/level
module mlab_stream_buf
    import mlab_dcfifo_pkg::*;
#(
    parameter int W     = 20,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = clog2_p1(DEPTH)
)(
    input  logic          i_clk,
    input  logic          i_arst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_head,
    output logic [LW-1:0] o_level,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rptr];
    assign w_pop_ok  = i_pop && !o_empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= i_push_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_level <= r_level + LW'(w_push_ok) - LW'(w_pop_ok);
        end
    end

endmodule

// File: rtl/mlab_dcfifo_stream_rd.sv
// rtl/mlab_dcfifo_stream_rd.sv - credit-based rdreq issue and show-ahead stream out of the MLAB DCFIFO; MLAB_DCFIFO_STREAM_PARITY_EN adds dout_err/parity_seen
module mlab_dcfifo_stream_rd
    import mlab_dcfifo_pkg::*;
#(
    parameter int LABS_WIDE = 1,
    parameter int RD_LAT    = RD_LAT_DEF,
    parameter int BUF_DEPTH = 4,
    localparam int W        = LABS_WIDE * WORD_W,
    localparam int LVL_W    = clog2_p1(BUF_DEPTH)
)(
    input  logic                   rdclk,
    input  logic                   arst_n,
    output logic                   rdreq,
    input  logic [W-1:0]           rddata,
    input  logic                   rdempty,
    input  logic [FIFO_USED_W-1:0] rdused,
    input  logic                   parity_err,
    output logic [W-1:0]           dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [LVL_W-1:0]       buf_level,
    output logic                   ovf_err
`ifdef MLAB_DCFIFO_STREAM_PARITY_EN
    ,
    output logic                   dout_err,
    output logic                   parity_seen
`endif
);

`ifdef MLAB_DCFIFO_STREAM_PARITY_EN
    localparam int BW = W + 1;
`else
    localparam int BW = W;
`endif
    localparam int CW = (LVL_W + 2 > FIFO_USED_W + 1) ? LVL_W + 2 : FIFO_USED_W + 1;

    logic              r_rdreq;
    logic [RD_LAT-1:0] r_pipe;
    logic              r_ovf;
    logic              w_ret;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_rdreq_nxt;
    logic [BW-1:0]     w_push_data;
    logic [BW-1:0]     w_head;
    logic [LVL_W-1:0]  w_level;
    logic [CW-1:0]     w_inflight;
    logic [CW-1:0]     w_unrefl;
    logic [CW-1:0]     w_commit;

    assign w_ret = r_pipe[RD_LAT-1];
    assign w_pop = !w_empty && dout_ready;

    // Every slot already promised (stored, in flight, issued now) must fit before another read;
    // a head leaving this cycle frees its slot, which keeps back-to-back reads going.
    always_comb begin
        w_inflight = '0;
        w_unrefl   = CW'(r_rdreq);
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_pipe[i]);
            if (i < RD_LAT - 1) begin
                w_unrefl = w_unrefl + CW'(r_pipe[i]);
            end
        end
        w_commit    = CW'(w_level) + w_inflight + CW'(r_rdreq) - CW'(w_pop);
        w_rdreq_nxt = !rdempty && (CW'(rdused) > w_unrefl) && (w_commit < CW'(BUF_DEPTH));
    end

    always_ff @(posedge rdclk or negedge arst_n) begin
        if (!arst_n) begin
            r_rdreq <= 1'b0;
            r_pipe  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_rdreq <= w_rdreq_nxt;
            r_pipe  <= (r_pipe << 1) | RD_LAT'(r_rdreq);
            if (w_ret && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef MLAB_DCFIFO_STREAM_PARITY_EN
    logic r_parity_seen;

    always_ff @(posedge rdclk or negedge arst_n) begin
        if (!arst_n) begin
            r_parity_seen <= 1'b0;
        end else if (w_ret && parity_err) begin
            r_parity_seen <= 1'b1;
        end
    end

    assign w_push_data = {parity_err, rddata};
    assign dout_err    = w_head[W];
    assign parity_seen = r_parity_seen;
`else
    logic w_unused_perr;

    assign w_unused_perr = parity_err;
    assign w_push_data   = rddata;
`endif

    mlab_stream_buf #(
        .W     (BW),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .i_clk       (rdclk),
        .i_arst_n    (arst_n),
        .i_push      (w_ret),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_level     (w_level),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign rdreq      = r_rdreq;
    assign dout       = w_head[W-1:0];
    assign dout_valid = !w_empty;
    assign buf_level  = w_level;
    assign ovf_err    = r_ovf;

endmodule

// File: tb/tb_mlab_dcfifo_stream_rd.sv
// tb/tb_mlab_dcfifo_stream_rd.sv - scoreboard bench for mlab_dcfifo_stream_rd against a DCFIFO read-port model
module tb_mlab_dcfifo_stream_rd;

    localparam int W        = 20;
    localparam int LVL_W    = 3;
    localparam int RD_LAT   = 2;
    localparam int FIFO_CAP = 32;

    logic             rdclk = 1'b0;
    logic             arst_n;
    logic             rdreq;
    logic [W-1:0]     rddata;
    logic             rdempty;
    logic [5:0]       rdused;
    logic             parity_err;
    logic [W-1:0]     dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [LVL_W-1:0] buf_level;
    logic             ovf_err;
`ifdef MLAB_DCFIFO_STREAM_PARITY_EN
    logic             dout_err;
    logic             parity_seen;
`endif

    always #5 rdclk = ~rdclk;

    mlab_dcfifo_stream_rd dut (
        .rdclk      (rdclk),
        .arst_n     (arst_n),
        .rdreq      (rdreq),
        .rddata     (rddata),
        .rdempty    (rdempty),
        .rdused     (rdused),
        .parity_err (parity_err),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .buf_level  (buf_level),
        .ovf_err    (ovf_err)
`ifdef MLAB_DCFIFO_STREAM_PARITY_EN
        ,
        .dout_err    (dout_err),
        .parity_seen (parity_seen)
`endif
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [W:0] fifo_q[$];
    logic [W:0] exp_q[$];
    logic [W:0] s0, s1;
    logic       h0, h1;
    int         cyc, rd_cnt, beat_cnt, underflow;
    int         first_rd_cyc, first_beat_cyc, last_beat_cyc, run_len, max_run;
    bit         force_empty, wr_rand;
    int         ready_mode;
    int         wr_val, perr_val;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic update_flags();
        int u;
        u       = fifo_q.size() + int'(h0) + int'(h1);
        rdused  = (u > 63) ? 6'd63 : 6'(u);
        rdempty = force_empty || (fifo_q.size() == 0);
    endtask

    task automatic push_word();
        logic [W:0] w;
        if (fifo_q.size() < FIFO_CAP) begin
            w = {(wr_val == perr_val), W'(wr_val)};
            fifo_q.push_back(w);
            exp_q.push_back(w);
            wr_val++;
        end
        update_flags();
    endtask

    task automatic clr_stats();
        rd_cnt = 0; beat_cnt = 0; underflow = 0; run_len = 0; max_run = 0;
        first_rd_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1;
    endtask

    // One read-clock cycle: FIFO read-port model, then the stream consumer.
    task automatic tick();
        logic [W:0] e;
        @(negedge rdclk);
        cyc++;
        rddata     = s1[W-1:0];
        parity_err = s1[W];
        s1         = s0;
        s0         = '0;
        if (rdreq) begin
            rd_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            if (fifo_q.size() == 0) underflow++;
            else s0 = fifo_q.pop_front();
        end else begin
            run_len = 0;
        end
        h1 = h0;
        h0 = rdreq;
        if (wr_rand && ($urandom_range(1899, 0) < 1600)) push_word();
        update_flags();
        case (ready_mode)
            0:       dout_ready = 1'b0;
            1:       dout_ready = 1'b1;
            default: dout_ready = 1'($urandom_range(1, 0));
        endcase
        if (dout_valid && dout_ready) begin
            beat_cnt++;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            check_eq("sb_expect_beat", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("dout", 32'(dout), 32'(e[W-1:0]));
`ifdef MLAB_DCFIFO_STREAM_PARITY_EN
                check_eq("dout_err", 32'(dout_err), 32'(e[W]));
`endif
            end
        end
    endtask

    task automatic hw_reset(input bit keep_flight);
        arst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        h0 = 1'b0;
        h1 = 1'b0;
        if (!keep_flight) begin
            s0 = '0;
            s1 = '0;
        end
        update_flags();
    endtask

    task automatic drain(input string tag);
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int changes;
        logic [W-1:0] held;
        bit seen;
        cyc = 0; s0 = '0; s1 = '0; h0 = 1'b0; h1 = 1'b0;
        rddata = '0; parity_err = 1'b0; dout_ready = 1'b0;
        force_empty = 1'b0; wr_rand = 1'b0; ready_mode = 0;
        wr_val = 0; perr_val = -1;
        clr_stats();
        hw_reset(1'b0);
        repeat (3) tick();
        check_eq("rst_rdreq", 32'(rdreq), 0);
        check_eq("rst_valid", 32'(dout_valid), 0);
        check_eq("rst_dout", 32'(dout), 0);
        check_eq("rst_level", 32'(buf_level), 0);
        check_eq("rst_ovf", 32'(ovf_err), 0);
`ifdef MLAB_DCFIFO_STREAM_PARITY_EN
        check_eq("rst_parity_seen", 32'(parity_seen), 0);
`endif
        arst_n = 1'b1;

        // Streaming: 32 preloaded words, ready always high
        clr_stats(); ready_mode = 1; wr_val = 0; perr_val = 7;
        repeat (32) push_word();
        drain("stream_drain");
        repeat (4) tick();
        check_eq("stream_rd_cnt", rd_cnt, 32);
        check_eq("stream_rd_run", max_run, 32);
        check_eq("stream_latency", first_beat_cyc - first_rd_cyc, RD_LAT + 1);
        check_eq("stream_no_gap", last_beat_cyc - first_beat_cyc, 31);
        check_eq("stream_beats", beat_cnt, 32);
        check_eq("stream_underflow", underflow, 0);
`ifdef MLAB_DCFIFO_STREAM_PARITY_EN
        check_eq("parity_seen", 32'(parity_seen), 1);
`endif
        perr_val = -1;

        // Backpressure: ready low, 20 words available
        hw_reset(1'b0); tick(); arst_n = 1'b1;
        clr_stats(); ready_mode = 0; wr_val = 0;
        repeat (20) push_word();
        changes = 0; seen = 1'b0; held = '0;
        repeat (20) begin
            tick();
            if (dout_valid) begin
                if (seen && (dout != held)) changes++;
                held = dout;
                seen = 1'b1;
            end
        end
        check_eq("bp_rd_cnt", rd_cnt, 4);
        check_eq("bp_level", 32'(buf_level), 4);
        check_eq("bp_valid", 32'(dout_valid), 1);
        check_eq("bp_dout", 32'(dout), 0);
        check_eq("bp_hold", changes, 0);
        drain("bp_drain");
        check_eq("bp_ovf", 32'(ovf_err), 0);

        // Near-empty: a single word, then rdempty forced high
        hw_reset(1'b0); tick(); arst_n = 1'b1;
        clr_stats(); ready_mode = 1; wr_val = 0;
        push_word();
        repeat (12) tick();
        check_eq("ne_rd_cnt", rd_cnt, 1);
        check_eq("ne_drain", exp_q.size(), 0);
        check_eq("ne_underflow", underflow, 0);
        clr_stats(); force_empty = 1'b1;
        repeat (5) push_word();
        repeat (12) tick();
        check_eq("empty_rd_cnt", rd_cnt, 0);
        check_eq("empty_valid", 32'(dout_valid), 0);
        force_empty = 1'b0;
        update_flags();
        drain("empty_drain");

        // Reset mid-stream with a word still arriving on rddata
        hw_reset(1'b0); tick(); arst_n = 1'b1;
        clr_stats(); ready_mode = 0; wr_val = 0;
        repeat (10) push_word();
        for (int i = 0; i < 20; i++) begin
            if (buf_level == 3) break;
            tick();
        end
        check_eq("mid_level3", 32'(buf_level), 3);
        hw_reset(1'b1);
        #1;
        check_eq("mid_rst_valid", 32'(dout_valid), 0);
        check_eq("mid_rst_rdreq", 32'(rdreq), 0);
        check_eq("mid_rst_level", 32'(buf_level), 0);
        #1;
        arst_n = 1'b1;
        clr_stats(); ready_mode = 1;
        repeat (10) tick();
        check_eq("mid_no_stale", beat_cnt, 0);
        check_eq("mid_level_after", 32'(buf_level), 0);
        repeat (8) push_word();
        drain("mid_drain");

        // Random ready against a live FIFO writing ~1600/1900 of cycles
        hw_reset(1'b0); tick(); arst_n = 1'b1;
        clr_stats(); ready_mode = 2; wr_val = 0; wr_rand = 1'b1;
        repeat (3000) tick();
        wr_rand = 1'b0;
        drain("rnd_drain");
        check_eq("rnd_beats", beat_cnt, wr_val);
        check_eq("rnd_ovf", 32'(ovf_err), 0);
        check_eq("rnd_underflow", underflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mlab_dcfifo_stream_rd.md
Name: mlab_dcfifo_stream_rd

Overview:
- Read-side consumer placed directly downstream of the MLAB dual-clock FIFO, in the read-clock domain.
- Converts the FIFO's fixed-latency rdreq/rddata read port into a show-ahead valid/ready stream.
- Issues rdreq using credit-based flow control and the FIFO's rdused count.
- Catches returning words in a small register buffer so downstream backpressure never loses data.

Parameters:
- LABS_WIDE, 1, data width multiplier; word width W = LABS_WIDE*20.
- RD_LAT, 2, cycles from rdreq high to valid rddata.
- BUF_DEPTH, 4, output buffer entries; must be >= RD_LAT+2, power of two.

Ports:
- rdclk  in  1  read-domain clock, shared with the FIFO read side
- arst_n  in  1  asynchronous active-low reset
- rdreq  out  1  read request to FIFO
- rddata  in  W  FIFO read data, valid RD_LAT cycles after rdreq
- rdempty  in  1  FIFO empty flag
- rdused  in  6  FIFO read-side occupancy
- parity_err  in  1  FIFO parity error, aligned with rddata
- dout  out  W  stream data, held while dout_valid && !dout_ready
- dout_valid  out  1  stream valid
- dout_ready  in  1  stream ready
- buf_level  out  $clog2(BUF_DEPTH)+1  output buffer occupancy
- ovf_err  out  1  sticky: a return arrived with the buffer full (design bug indicator)

Behaviour:
- Reset: rdreq=0, dout_valid=0, dout=0, buf_level=0, ovf_err=0. All internal state is cleared: pipeline, pointers, credit count.
- Read-valid pipeline: an RD_LAT-deep shift register of issued rdreq bits. Tap RD_LAT marks a returning word, which is written into the buffer in that cycle.
- inflight = number of ones in the pipeline, range 0..RD_LAT.
- Credit rule: rdreq (registered) asserts next cycle iff all three hold:
  - rdempty==0;
  - rdused > inflight_unreflected, where inflight_unreflected counts reads issued in the last RD_LAT cycles;
  - buf_level + inflight + rdreq_now < BUF_DEPTH.
- Back-to-back rdreq is permitted when the rule holds every cycle.
- Buffer: circular, BUF_DEPTH entries, show-ahead. dout is the head entry; dout_valid = (buf_level != 0). The head pops on dout_valid && dout_ready.
- A return and a pop in the same cycle leave buf_level unchanged and both pointers advance. An empty buffer with a simultaneous return shows the word one cycle later; there is no combinational bypass.
- Pointers wrap modulo BUF_DEPTH.
- A return with buf_level==BUF_DEPTH and no pop sets ovf_err and drops the word. This is unreachable under the credit rule.
- Order is strictly preserved: words leave in FIFO read order.
- Throughput: with dout_ready held high and the FIFO non-empty, one word per cycle after an initial latency of RD_LAT+2 cycles from the first rdreq decision.
- rdempty high mid-stream: no further rdreq. Words in flight still return and are buffered.
- Reset mid-operation: all in-flight returns are discarded, including any that arrive after reset deasserts while the pipeline is cleared. Upstream FIFO reset must accompany this block's reset.

Optional Feature:
- Macro MLAB_DCFIFO_STREAM_PARITY_EN.
- Defined:
  - parity_err is captured with each returning word into a per-entry bit.
  - Extra port dout_err out 1 presents that bit with dout.
  - Extra port parity_seen out 1 is sticky and cleared only by reset.
- Undefined: parity_err is ignored, and dout_err and parity_seen are absent.

Decomposition:
- Package mlab_dcfifo_pkg holds:
  - constants WORD_W=20 and FIFO_USED_W=6;
  - default RD_LAT=2;
  - function clog2_p1 for level widths.
- One sub-module, mlab_stream_buf: a parameterised W x BUF_DEPTH register circular buffer with push/pop/level/full/empty. The top keeps the credit logic and read-valid pipeline.

Test Plan:
- Reset: assert arst_n=0 mid-stream with buf_level=3 -> immediately dout_valid=0, rdreq=0, buf_level=0. After release, no stale word appears.
- Streaming: FIFO preloaded 0..31, dout_ready=1 constant -> rdreq high 32 consecutive cycles, dout sequence 0..31 one per cycle, no gaps after the first word.
- Backpressure: dout_ready=0 with FIFO holding 20 words -> rdreq stops after exactly BUF_DEPTH=4 issues, buf_level=4, dout=0 held stable. Releasing ready yields 1,2,3,... in order.
- Near-empty: rdused=1 -> exactly one rdreq until rdused updates, no read of an empty FIFO. rdempty=1 -> rdreq stays 0.
- Random: random dout_ready (50%) against a live FIFO with write rate 1600/1900 clock ratio, 10 ms -> dout increments by 1 every accepted beat, ovf_err never set.
- Parity (macro defined): inject parity_err with the word of value 7 -> dout_err=1 only on that beat, parity_seen=1 thereafter.
